pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the five-stage MIPS datapath. It replaces the fixed per-stage latches between stages, such as the E→M latch. It carries an arbitrary-width packed payload (instr, pc, ALU result, rt, HI/LO, flags) under a valid/ready handshake, with a synchronous flush that inserts a bubble. An optional two-entry skid mode cuts the combinational ready path between stages.

---
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush to a bubble,
// and an optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int              DATA_W  = 32,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter bit              SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_next;
    logic              skid_valid;
    logic              accept;
    logic              consume;

    assign out_valid  = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign out_data   = main_q;
    assign occupancy  = state;
    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;

    // Skid mode decodes in_ready from state only, so out_ready never reaches it.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready = !skid_valid;
        end else begin : g_comb_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end

    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = EMPTY;
            main_next  = BUBBLE;
            skid_next  = BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_next = in_data;
                    end else if (accept) begin
                        // Only reachable with the skid buffer; without it accept implies consume.
                        if (SKID_EN) begin
                            state_next = FULL;
                            skid_next  = in_data;
                        end
                    end else if (consume) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_next = ONE;
                        main_next  = skid_q;
                        skid_next  = BUBBLE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = BUBBLE;
                    skid_next  = BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid-mode and one single-register instance
// share clock and reset; monitors pop expected payloads whenever a DUT output is consumed.
module tb_pipe_stage_reg;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;

    logic          a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0, a_out_valid, a_out_ready = 1'b0;
    logic [DW-1:0] a_in_data = '0, a_out_data;
    logic [1:0]    a_occ;

    logic          b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0, b_out_valid, b_out_ready = 1'b0;
    logic [DW-1:0] b_in_data = '0, b_out_data;
    logic [1:0]    b_occ;

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];
    int            checks = 0;
    int            errors = 0;

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE('0), .SKID_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE('0), .SKID_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input bit sel_b, input logic valid, input logic [DW-1:0] data,
                                  input logic oready, input logic fl);
        if (!sel_b) begin
            a_in_valid = valid; a_in_data = data; a_out_ready = oready; a_flush = fl;
        end else begin
            b_in_valid = valid; b_in_data = data; b_out_ready = oready; b_flush = fl;
        end
        #1;
    endtask

    // Monitors pop at the falling edge; the driver records accepts/flushes just after,
    // so a same-cycle consume is retired before a flush clears or an accept appends.
    task automatic end_cycle();
        @(negedge clk);
        #1;
        if (a_flush) q_a.delete();
        else if (a_in_valid && a_in_ready) q_a.push_back(a_in_data);
        if (b_flush) q_b.delete();
        else if (b_in_valid && b_in_ready) q_b.push_back(b_in_data);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && a_out_valid && a_out_ready) begin
            check_output("a_no_dead", {31'd0, a_out_data == 16'hDEAD}, 32'd0);
            if (q_a.size() == 0) check_output("a_unexpected_output", a_out_data, 32'hFFFF_FFFF);
            else check_output("a_out_data", a_out_data, q_a.pop_front());
        end
        if (reset && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) check_output("b_unexpected_output", b_out_data, 32'hFFFF_FFFF);
            else check_output("b_out_data", b_out_data, q_b.pop_front());
        end
    end

    initial begin
        // Reset state before any clock edge
        #2;
        check_output("a_rst_out_valid", a_out_valid, 0);
        check_output("a_rst_out_data", a_out_data, 0);
        check_output("a_rst_in_ready", a_in_ready, 1);
        check_output("a_rst_occ", a_occ, 0);
        check_output("b_rst_in_ready", b_in_ready, 1);
        check_output("b_rst_occ", b_occ, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            end_cycle();
            check_output("a_idle_out_valid", a_out_valid, 0);
            check_output("a_idle_occ", a_occ, 0);
            check_output("a_idle_in_ready", a_in_ready, 1);
        end

        // Back-to-back streaming, skid mode
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 1, 16'h1000 + DW'(i), 1, 0);
            check_output("a_stream_in_ready", a_in_ready, 1);
            end_cycle();
            check_output("a_stream_out_valid", a_out_valid, 1);
            check_output("a_stream_out_data", a_out_data, 16'h1000 + i);
        end
        apply_stimulus(0, 0, 0, 1, 0);
        end_cycle();
        check_output("a_stream_drained_occ", a_occ, 0);

        // Backpressure into skid
        apply_stimulus(0, 1, 16'h00A0, 1, 0);
        end_cycle();
        apply_stimulus(0, 1, 16'h00A1, 0, 0);
        check_output("a_bp_in_ready_before", a_in_ready, 1);
        end_cycle();
        check_output("a_bp_occ_full", a_occ, 2);
        check_output("a_bp_in_ready_full", a_in_ready, 0);
        check_output("a_bp_main_held", a_out_data, 16'h00A0);
        apply_stimulus(0, 1, 16'h00A2, 0, 0);
        end_cycle();
        check_output("a_bp_hold_occ", a_occ, 2);
        apply_stimulus(0, 1, 16'h00A2, 1, 0);
        check_output("a_bp_in_ready_at_consume", a_in_ready, 0);
        end_cycle();
        check_output("a_bp_occ_one", a_occ, 1);
        check_output("a_bp_in_ready_back", a_in_ready, 1);
        check_output("a_bp_main_from_skid", a_out_data, 16'h00A1);
        apply_stimulus(0, 1, 16'h00A2, 1, 0);
        end_cycle();
        apply_stimulus(0, 0, 0, 1, 0);
        end_cycle();
        check_output("a_bp_drained_occ", a_occ, 0);

        // Flush while FULL with a pending 0xDEAD
        apply_stimulus(0, 1, 16'h00B0, 0, 0);
        end_cycle();
        apply_stimulus(0, 1, 16'h00B1, 0, 0);
        end_cycle();
        check_output("a_fl_pre_occ", a_occ, 2);
        apply_stimulus(0, 1, 16'hDEAD, 0, 1);
        end_cycle();
        check_output("a_fl_occ", a_occ, 0);
        check_output("a_fl_out_valid", a_out_valid, 0);
        check_output("a_fl_out_data", a_out_data, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        end_cycle();
        check_output("a_fl_stays_empty", a_out_valid, 0);

        // Flush in ONE with simultaneous accept and consume: C0 leaves, C1 dropped
        apply_stimulus(0, 1, 16'h00C0, 1, 0);
        end_cycle();
        apply_stimulus(0, 1, 16'h00C1, 1, 1);
        check_output("a_fl1_in_ready", a_in_ready, 1);
        end_cycle();
        check_output("a_fl1_occ", a_occ, 0);
        check_output("a_fl1_out_data", a_out_data, 0);
        apply_stimulus(0, 0, 0, 1, 0);
        end_cycle();

        // Single-register mode: combinational in_ready
        apply_stimulus(1, 1, 16'h0044, 0, 0);
        end_cycle();
        apply_stimulus(1, 1, 16'h0055, 0, 0);
        check_output("b_in_ready_blocked", b_in_ready, 0);
        apply_stimulus(1, 1, 16'h0055, 1, 0);
        check_output("b_in_ready_comb", b_in_ready, 1);
        end_cycle();
        check_output("b_main_replaced", b_out_data, 16'h0055);
        check_output("b_occ_one", b_occ, 1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 1, 16'h0060 + DW'(i), 1, 0);
            end_cycle();
            check_output("b_stream_out_data", b_out_data, 16'h0060 + i);
        end
        apply_stimulus(1, 0, 0, 1, 0);
        end_cycle();
        check_output("b_drained_occ", b_occ, 0);

        // Asynchronous reset mid-stream while FULL
        apply_stimulus(0, 1, 16'h00D0, 0, 0);
        end_cycle();
        apply_stimulus(0, 1, 16'h00D1, 0, 0);
        end_cycle();
        check_output("a_ar_pre_occ", a_occ, 2);
        apply_stimulus(0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check_output("a_ar_out_valid", a_out_valid, 0);
        check_output("a_ar_occ", a_occ, 0);
        check_output("a_ar_in_ready", a_in_ready, 1);
        q_a.delete();
        #1;
        reset = 1'b1;
        end_cycle();
        check_output("a_ar_after_occ", a_occ, 0);

        check_output("a_queue_empty", q_a.size(), 0);
        check_output("b_queue_empty", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
